// File: rtl/clock_group_reset_sequencer.sv
// clock_group_reset_sequencer
// Takes one group clock and its raw asynchronous reset. Reset deassertion is
// synchronised first. The member-domain resets are then released one at a time,
// in ascending index order, STAGGER_CYCLES apart. The block can also re-run the
// whole sequence when software requests it.
//
// Request semantics: io_sw_reset_req is a plain level with no handshake. It is
// sampled only while the FSM is in RUN. It is never queued, so a request seen in
// SYNC, HOLD or STAGGER has no effect. A level held high re-triggers the
// sequence at every entry to RUN.
//
// io_dbg_state exposes the FSM state: 0 = SYNC, 1 = HOLD, 2 = STAGGER, 3 = RUN.

`timescale 1ns/1ps

module clock_group_reset_sequencer #(
  parameter int NUM_MEMBERS    = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int STAGGER_CYCLES = 4,
  parameter int HOLD_CYCLES    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_sw_reset_req,
  output logic [NUM_MEMBERS-1:0] io_member_reset,
  output logic                   io_all_released,
  output logic                   io_busy,
  output logic [1:0]             io_dbg_state
);

  localparam int CNT_MAX = (STAGGER_CYCLES > HOLD_CYCLES) ? STAGGER_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_MEMBERS + 1);

  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_MEMBERS - 1);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_STAGGER = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_MEMBERS-1:0] member_q, member_d;
  logic                   all_rel_q, all_rel_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_rst;

  // Reset-release synchroniser: the flops are set asynchronously by reset, and a
  // zero shifts through them once reset has fallen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign sync_rst = sync_q[SYNC_STAGES-1];

  // State, counter and output registers. Reset forces every member back into reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SYNC;
      cnt_q     <= '0;
      idx_q     <= '0;
      member_q  <= '1;
      all_rel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      member_q  <= member_d;
      all_rel_q <= all_rel_d;
    end
  end

  // Next-state logic. Releases only ever clear member bits, and the only path that
  // sets them again is a software request taken in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    member_d  = member_q;
    all_rel_d = all_rel_q;

    unique case (state_q)
      ST_SYNC, ST_HOLD: begin
        // SYNC waits for the synchronised reset to drop; HOLD waits for its count
        // to finish. Both then leave the same way: member 0 is released first.
        if ((state_q == ST_SYNC && !sync_rst) ||
            (state_q == ST_HOLD && cnt_q == HOLD_LAST)) begin
          member_d[0] = 1'b0;
          cnt_d       = '0;
          idx_d       = IDX_W'(1);
          if (NUM_MEMBERS == 1) begin
            state_d   = ST_RUN;
            all_rel_d = 1'b1;
          end else begin
            state_d   = ST_STAGGER;
          end
        end else if (state_q == ST_HOLD) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STAGGER: begin
        if (cnt_q == STAG_LAST) begin
          for (int k = 0; k < NUM_MEMBERS; k++) begin
            if (idx_q == IDX_W'(k)) member_d[k] = 1'b0;
          end
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          // Releasing the last member completes the sequence on this same edge.
          if (idx_q == IDX_LAST) begin
            state_d   = ST_RUN;
            all_rel_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (io_sw_reset_req) begin
          member_d  = '1;
          all_rel_d = 1'b0;
          cnt_d     = '0;
          idx_d     = '0;
          state_d   = ST_HOLD;
        end
      end

      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  assign io_member_reset = member_q;
  assign io_all_released = all_rel_q;
  assign io_busy         = ~all_rel_q;
  assign io_dbg_state    = state_q;

endmodule
